// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared word width, serializer states and index-width helper
package mm_pkg;

  localparam int WORD_W = 32;

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  // Width of an index over x items, never narrower than one bit.
  function automatic int idx_w(input int x);
    if (x <= 1) return 1;
    return $clog2(x);
  endfunction

endpackage

// File: rtl/matrix_result_serializer.sv
// rtl/matrix_result_serializer.sv - captures a result matrix and streams it word by word, row-major
module matrix_result_serializer
  import mm_pkg::*;
#(
  parameter int n = 2,
  parameter int p = 2,
  localparam int RW = idx_w(n),
  localparam int CW = idx_w(p)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [0:WORD_W*n*p-1]     in_matrix,
  input  logic                      in_stb,
  output logic                      in_ack,
  output logic [WORD_W-1:0]         out_data,
  output logic [RW-1:0]             out_row,
  output logic [CW-1:0]             out_col,
  output logic                      out_last,
  output logic                      out_stb,
  input  logic                      out_ack
);

  localparam int NE = n * p;
  localparam int KW = idx_w(NE);
  localparam int BW = WORD_W * NE;

  state_t              state, state_n;
  logic [KW-1:0]       k, k_n;
  logic [RW-1:0]       row_n;
  logic [CW-1:0]       col_n;
  logic [WORD_W-1:0]   data_n;
  logic                last_n;
  logic                stb_n;
  logic                ack_n;
  logic                load;
  logic [0:BW-1]       cap_buf;

  // Next-state and next-output decode; every output is a register fed from here.
  always_comb begin
    state_n = state;
    k_n     = k;
    row_n   = out_row;
    col_n   = out_col;
    data_n  = out_data;
    last_n  = out_last;
    stb_n   = out_stb;
    ack_n   = in_ack;
    load    = 1'b0;
    case (state)
      IDLE: begin
        ack_n = 1'b1;
        stb_n = 1'b0;
        if (in_stb && in_ack) begin
          // Element 0 comes straight from the input so the first word is
          // valid the cycle after capture, without waiting on the buffer.
          load    = 1'b1;
          ack_n   = 1'b0;
          stb_n   = 1'b1;
          data_n  = in_matrix[0 +: WORD_W];
          row_n   = '0;
          col_n   = '0;
          k_n     = '0;
          last_n  = (NE == 1);
          state_n = SEND;
        end
      end
      SEND: begin
        ack_n = 1'b0;
        if (out_ack) begin
          if (out_last) begin
            stb_n   = 1'b0;
            last_n  = 1'b0;
            ack_n   = 1'b1;
            state_n = IDLE;
          end else begin
            k_n = k + 1'b1;
            if (out_col == CW'(p - 1)) begin
              col_n = '0;
              row_n = out_row + 1'b1;
            end else begin
              col_n = out_col + 1'b1;
            end
            data_n = cap_buf[int'(k_n) * WORD_W +: WORD_W];
            last_n = (k_n == KW'(NE - 1));
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset drops any stream in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      k        <= '0;
      in_ack   <= 1'b0;
      out_stb  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_row  <= '0;
      out_col  <= '0;
    end else begin
      state    <= state_n;
      k        <= k_n;
      in_ack   <= ack_n;
      out_stb  <= stb_n;
      out_last <= last_n;
      out_data <= data_n;
      out_row  <= row_n;
      out_col  <= col_n;
    end
  end

  // Capture buffer decouples the stream from later changes on in_matrix.
  always_ff @(posedge clk) begin
    if (load) cap_buf <= in_matrix;
  end

endmodule
